// File: rtl/ip_uart_rx.sv
// ip_uart_rx: 8N1 UART receiver with a mid-bit sampling timer and a one-entry
// valid/ready output buffer.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing plus a parity_error pulse).
module ip_uart_rx #(
    parameter int unsigned CLK_FREQ = 86_400_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_error,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_error,
`endif
    output logic       busy
);

    localparam int unsigned DIV  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned TW   = $clog2(DIV);

    localparam logic [TW-1:0] DIV_M1  = TW'(DIV - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);

    // Bit timer needs enough oversampling to find the bit centre reliably
    if (DIV < 16) begin : g_div_check
        $error("ip_uart_rx: CLK_FREQ/BAUD must be at least 16");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state, state_next;
    logic          rx_meta, rxs;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic          deliver_next, deliver_q;
    logic          ferr_next;
    logic          tick;
`ifdef UART_RX_PARITY_EN
    logic          par_bit, par_bit_next;
`endif

    assign tick = (timer == '0);

    // Synchronizer, state register and frame datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_bit_next;
`endif
        end
    end

    // Next-state, timer and shift-register control
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        deliver_next = 1'b0;
        ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next = par_bit;
`endif
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    timer_next = HALF_M1;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (!tick) begin
                    timer_next = timer - TW'(1);
                end else if (rxs) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next   = DIV_M1;
                    bit_idx_next = '0;
                    state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    timer_next = timer - TW'(1);
                end else begin
                    shift_next   = {rxs, shift[7:1]};
                    timer_next   = DIV_M1;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!tick) begin
                    timer_next = timer - TW'(1);
                end else begin
                    par_bit_next = rxs;
                    timer_next   = DIV_M1;
                    state_next   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!tick) begin
                    timer_next = timer - TW'(1);
                end else if (rxs) begin
                    deliver_next = 1'b1;
                    state_next   = S_IDLE;
                end else begin
                    ferr_next  = 1'b1;
                    state_next = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output buffer, handshake and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            deliver_q     <= 1'b0;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
        end else begin
            deliver_q     <= deliver_next;
            framing_error <= ferr_next;
            overrun       <= 1'b0;
            busy          <= (state_next != S_IDLE);
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (deliver_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_error <= ^{shift, par_bit};
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ip_uart_rx.sv
// tb_ip_uart_rx: directed frames with an event scoreboard for ip_uart_rx.
// Bit period is 250 clocks so the full sequence stays short.
module tb_ip_uart_rx;

    localparam int unsigned CLK_FREQ = 28_800_000;
    localparam int unsigned BAUD     = 115_200;
    localparam int DIV  = 250;
    localparam int HALF = 125;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int EV_DATA = 0;
    localparam int EV_FERR = 1;
    localparam int EV_OVR  = 2;
    localparam int EV_NONE = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       perr;
        int         t;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_error;
    logic       overrun;
    logic       busy;
    logic       perr_obs;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    logic       pv = 1'b0, ptake = 1'b0, pfe = 1'b0, pov = 1'b0;
    logic [7:0] pdata = 8'h00;
    logic       new_byte;

`ifdef UART_RX_PARITY_EN
    logic parity_error;
    assign perr_obs = parity_error;
`else
    assign perr_obs = 1'b0;
`endif

    ip_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk),
        .reset(reset),
        .uart_rx(uart_rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .framing_error(framing_error),
        .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .parity_error(parity_error),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A new byte is visible when valid rises or a consume coincided with a delivery
    assign new_byte = rx_valid && (!pv || ptake);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic match(input int kind, input logic [7:0] d, input logic pe);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data 0x%02h at cycle %0d, expected none",
                     kind, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_DATA && (e.data != d || e.perr != pe)) ||
                cyc < e.t - 2 || cyc > e.t + 2) begin
                errors++;
                $display("FAIL event: got kind %0d data 0x%02h perr %0d cycle %0d, expected kind %0d data 0x%02h perr %0d cycle %0d+-2",
                         kind, d, pe, cyc, e.kind, e.data, e.perr, e.t);
            end
        end
    endtask

    // Compare process: every observed event must match the next expected frame outcome
    always @(negedge clk) begin
        if (reset) begin
            pv    <= 1'b0;
            ptake <= 1'b0;
            pfe   <= 1'b0;
            pov   <= 1'b0;
        end else begin
            if (new_byte)      match(EV_DATA, rx_data, perr_obs);
            if (framing_error) match(EV_FERR, 8'h00, 1'b0);
            if (overrun)       match(EV_OVR, 8'h00, 1'b0);
            if (pv && !ptake) begin
                check("hold_valid", int'(rx_valid), 1);
                check("hold_data", int'(rx_data), int'(pdata));
            end
            if (pfe) check("ferr_width", int'(framing_error), 0);
            if (pov) check("ovr_width", int'(overrun), 0);
`ifdef UART_RX_PARITY_EN
            if (perr_obs) check("perr_with_delivery", int'(new_byte), 1);
`endif
            pv    <= rx_valid;
            ptake <= rx_valid & rx_ready;
            pdata <= rx_data;
            pfe   <= framing_error;
            pov   <= overrun;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame and record the outcome it must produce
    task automatic send(input logic [7:0] b, input bit stop_hi, input bit par_good, input int kind);
        ev_t  e;
        logic par;
        par    = par_good ? ^b : ~(^b);
        e.kind = kind;
        e.data = b;
`ifdef UART_RX_PARITY_EN
        e.perr = ^{b, par};
`else
        e.perr = 1'b0;
`endif
        e.t = cyc + 2 + HALF + NB * DIV + 1;
        if (kind != EV_NONE) exp_q.push_back(e);
        uart_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(DIV);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = par;
        tick(DIV);
`endif
        uart_rx = stop_hi;
        tick(DIV);
        uart_rx = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b1;
        tick(3);
        check("rst_data", int'(rx_data), 0);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ferr", int'(framing_error), 0);
        check("rst_ovr", int'(overrun), 0);
        reset = 1'b0;
        tick(1);

        // Idle line
        tick(20000);
        check("idle_valid", int'(rx_valid), 0);
        check("idle_busy", int'(busy), 0);

        // Plain byte, consumer always ready
        send(8'h55, 1'b1, 1'b1, EV_DATA);
        tick(2 * DIV);
        check("b55_data", int'(rx_data), 'h55);
        check("b55_valid_cleared", int'(rx_valid), 0);

        // Glitch shorter than half a bit
        uart_rx = 1'b0;
        tick(60);
        check("glitch_busy_hi", int'(busy), 1);
        tick(40);
        uart_rx = 1'b1;
        tick(HALF + 20);
        check("glitch_busy_lo", int'(busy), 0);
        check("glitch_valid", int'(rx_valid), 0);
        tick(DIV);

        // Low stop bit then a clean frame
        send(8'hA5, 1'b0, 1'b1, EV_FERR);
        tick(2 * DIV);
        check("ferr_valid", int'(rx_valid), 0);
        send(8'h3C, 1'b1, 1'b1, EV_DATA);
        tick(2 * DIV);
        check("b3c_data", int'(rx_data), 'h3C);

        // Back-to-back bytes with a stalled consumer
        rx_ready = 1'b0;
        send(8'h12, 1'b1, 1'b1, EV_DATA);
        send(8'h34, 1'b1, 1'b1, EV_OVR);
        tick(2 * DIV);
        check("ovr_held_valid", int'(rx_valid), 1);
        check("ovr_held_data", int'(rx_data), 'h12);
        rx_ready = 1'b1;
        tick(1);
        check("ovr_consumed", int'(rx_valid), 0);
        tick(DIV);

        // Reset during bit 4 of 0xFF
        uart_rx = 1'b0;
        tick(DIV);
        uart_rx = 1'b1;
        tick(4 * DIV + DIV / 2);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(rx_valid), 0);
        tick(5 * DIV);
        send(8'h81, 1'b1, 1'b1, EV_DATA);
        tick(2 * DIV);
        check("b81_data", int'(rx_data), 'h81);

`ifdef UART_RX_PARITY_EN
        // Wrong parity still delivers the byte
        send(8'h07, 1'b1, 1'b0, EV_DATA);
        tick(2 * DIV);
        check("b07_data", int'(rx_data), 'h07);
`endif

        tick(10);
        check("events_outstanding", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
